// File: rtl/voice_mixer.sv
// Scans the per-key voltage array one key per clock, gates each voice with its
// frame-start key snapshot, and emits one scaled, saturated sample per frame.
module voice_mixer #(
    parameter int NKEYS = 88,
    parameter int VW    = 16,
    parameter int SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VW*NKEYS-1:0]   volts,
    input  logic [NKEYS-1:0]      keys,
    output logic [VW-1:0]         out_sample,
    output logic [7:0]            out_voices,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int AW = VW + 7;
    localparam int KW = 7;
    localparam logic [KW-1:0] K_LAST = KW'(NKEYS - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-VW+1){1'b0}}, {(VW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-VW+1){1'b1}}, {(VW-1){1'b0}}};

    typedef enum logic [1:0] {SCAN, FINAL, WAIT} state_t;

    state_t               state_reg, state_next;
    logic [KW-1:0]        k_reg;
    logic signed [AW-1:0] acc_reg;
    logic [7:0]           cnt_reg;
    logic [NKEYS-1:0]     keys_q_reg;
    logic [VW-1:0]        out_sample_reg;
    logic [7:0]           out_voices_reg;
    logic                 out_valid_reg;

    logic                 scan_en;
    logic                 load_en;
    logic signed [AW-1:0] voice_ext [NKEYS];
    logic [NKEYS-1:0]     key_hit;
    logic signed [AW-1:0] sel_volt;
    logic                 sel_gate;
    logic signed [AW-1:0] scaled;
    logic [VW-1:0]        clamped;

    // Per-key sign extension and one-hot match against the scan index.
    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
            assign key_hit[gi]   = (k_reg == KW'(gi));
            assign voice_ext[gi] = {{(AW-VW){volts[gi*VW+VW-1]}}, volts[gi*VW +: VW]};
        end
    endgenerate

    always_comb begin
        sel_volt = '0;
        sel_gate = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (key_hit[i]) begin
                sel_volt = voice_ext[i];
                sel_gate = keys_q_reg[i];
            end
        end
    end

    // Arithmetic shift floors toward minus infinity; the clamp then fits VW bits.
    assign scaled = acc_reg >>> SHIFT;

    always_comb begin
        if (scaled > SAT_MAX) begin
            clamped = SAT_MAX[VW-1:0];
        end else if (scaled < SAT_MIN) begin
            clamped = SAT_MIN[VW-1:0];
        end else begin
            clamped = scaled[VW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SCAN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SCAN:    if (k_reg == K_LAST) state_next = FINAL;
            FINAL:   state_next = (!out_valid_reg || out_ready) ? SCAN : WAIT;
            WAIT:    if (out_ready) state_next = SCAN;
            default: state_next = SCAN;
        endcase
    end

    always_comb begin
        scan_en = 1'b0;
        load_en = 1'b0;
        case (state_reg)
            SCAN:    scan_en = 1'b1;
            FINAL:   load_en = !out_valid_reg || out_ready;
            WAIT:    load_en = out_ready;
            default: ;
        endcase
    end

    // A load both publishes the finished frame and restarts the scan with a
    // fresh key snapshot; in WAIT everything but the handshake is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg          <= '0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            keys_q_reg     <= '0;
            out_sample_reg <= '0;
            out_voices_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else if (load_en) begin
            out_sample_reg <= clamped;
            out_voices_reg <= cnt_reg;
            out_valid_reg  <= 1'b1;
            keys_q_reg     <= keys;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            k_reg          <= '0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (scan_en) begin
                if (sel_gate) begin
                    acc_reg <= acc_reg + sel_volt;
                    cnt_reg <= cnt_reg + 8'd1;
                end
                if (k_reg != K_LAST) begin
                    k_reg <= k_reg + KW'(1);
                end
            end
        end
    end

    assign out_sample = out_sample_reg;
    assign out_voices = out_voices_reg;
    assign out_valid  = out_valid_reg;

endmodule
